// File: rtl/pipe_stat_pkg.sv
// Shared constants for the pipeline statistics monitor: selector codes,
// FSM state encoding and default counter width.
package pipe_stat_pkg;

  localparam int unsigned DEF_CNT_W = 32;
  localparam int unsigned ZRUN_W    = 8;
  localparam int unsigned SEL_W     = 2;

  localparam logic [SEL_W-1:0] SEL_CYCLE  = 2'd0;
  localparam logic [SEL_W-1:0] SEL_STALL  = 2'd1;
  localparam logic [SEL_W-1:0] SEL_FLUSH  = 2'd2;
  localparam logic [SEL_W-1:0] SEL_RETIRE = 2'd3;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_e;

endpackage

// File: rtl/pipe_stat_monitor_sat_counter.sv
// Saturating up-counter: increments on en_i, holds at all-ones.
// Ports: clk_i clock, start_i async active-low clear, en_i count enable,
//        q_o current count.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk_i,
  input  logic         start_i,
  input  logic         en_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: step unless disabled or already saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q_o = cnt_q;

endmodule

// File: rtl/pipe_stat_monitor.sv
// Pipeline statistics monitor: saturating cycle/stall/flush/retire counters,
// end-of-program detection via a run of zero-instruction retirements, and a
// snapshot/acknowledge readout of the counters.
// Ports: clk_i clock; start_i async active-low clear; stall_i/flush_i/branch_i
//        hazard inputs; retire_valid_i/retire_instr_i write-back stage;
//        snap_req_i/snap_ack_i/snap_sel_i snapshot control;
//        snap_valid_o unread snapshot present; snap_data_o selected shadow
//        (combinational on snap_sel_i); done_o program ended, counters frozen.
module pipe_stat_monitor
  import pipe_stat_pkg::*;
#(
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned HALT_CYCLES = 4
) (
  input  logic             clk_i,
  input  logic             start_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             branch_i,
  input  logic             retire_valid_i,
  input  logic [31:0]      retire_instr_i,
  input  logic             snap_req_i,
  input  logic             snap_ack_i,
  input  logic [SEL_W-1:0] snap_sel_i,
  output logic             snap_valid_o,
  output logic [CNT_W-1:0] snap_data_o,
  output logic             done_o
);

  localparam logic [ZRUN_W:0] HALT_THR = (ZRUN_W+1)'(HALT_CYCLES);

  state_e state_q;
  state_e state_d;

  logic cnt_en_c;
  logic done_c;

  logic stall_inc_c;
  logic retire_inc_c;
  logic zero_ret_c;
  logic halt_hit_c;

  logic [ZRUN_W-1:0] zrun_q;
  logic [ZRUN_W-1:0] zrun_d;
  logic [ZRUN_W:0]   zrun_nxt_c;

  logic [CNT_W-1:0] cyc_cnt;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [CNT_W-1:0] retire_cnt;

  logic             snap_valid_q;
  logic             snap_valid_d;
  logic [CNT_W-1:0] shd_cyc_q;
  logic [CNT_W-1:0] shd_cyc_d;
  logic [CNT_W-1:0] shd_stall_q;
  logic [CNT_W-1:0] shd_stall_d;
  logic [CNT_W-1:0] shd_flush_q;
  logic [CNT_W-1:0] shd_flush_d;
  logic [CNT_W-1:0] shd_retire_q;
  logic [CNT_W-1:0] shd_retire_d;

  // Event decode; a stall coinciding with a branch is not a hazard stall.
  always_comb begin
    stall_inc_c  = stall_i && !branch_i;
    retire_inc_c = retire_valid_i && (retire_instr_i != 32'd0);
    zero_ret_c   = retire_valid_i && (retire_instr_i == 32'd0);
    zrun_nxt_c   = {1'b0, zrun_q} + (ZRUN_W+1)'(1);
    halt_hit_c   = zero_ret_c && (zrun_nxt_c == HALT_THR);
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: HALTED is terminal until reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:    if (halt_hit_c) state_d = ST_HALTED;
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_RUN;
    endcase
  end

  // FSM outputs: counting only while running.
  always_comb begin
    cnt_en_c = 1'b0;
    done_c   = 1'b0;
    case (state_q)
      ST_RUN:    cnt_en_c = 1'b1;
      ST_HALTED: done_c   = 1'b1;
      default:   cnt_en_c = 1'b0;
    endcase
  end

  sat_counter #(.W(CNT_W)) u_cyc_cnt (
    .clk_i   (clk_i),
    .start_i (start_i),
    .en_i    (cnt_en_c),
    .q_o     (cyc_cnt)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i   (clk_i),
    .start_i (start_i),
    .en_i    (cnt_en_c && stall_inc_c),
    .q_o     (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i   (clk_i),
    .start_i (start_i),
    .en_i    (cnt_en_c && flush_i),
    .q_o     (flush_cnt)
  );

  sat_counter #(.W(CNT_W)) u_retire_cnt (
    .clk_i   (clk_i),
    .start_i (start_i),
    .en_i    (cnt_en_c && retire_inc_c),
    .q_o     (retire_cnt)
  );

  // Zero-run tracking; bubbles leave the run untouched.
  always_comb begin
    zrun_d = zrun_q;
    if (cnt_en_c) begin
      if (zero_ret_c) begin
        if (zrun_q != '1) zrun_d = zrun_nxt_c[ZRUN_W-1:0];
      end else if (retire_valid_i) begin
        zrun_d = '0;
      end
    end
  end

  // Snapshot handshake: capture pre-increment values when empty; ack releases
  // and, being only honoured while valid, always beats a same-edge request.
  always_comb begin
    snap_valid_d = snap_valid_q;
    shd_cyc_d    = shd_cyc_q;
    shd_stall_d  = shd_stall_q;
    shd_flush_d  = shd_flush_q;
    shd_retire_d = shd_retire_q;
    if (snap_valid_q) begin
      if (snap_ack_i) snap_valid_d = 1'b0;
    end else if (snap_req_i) begin
      snap_valid_d = 1'b1;
      shd_cyc_d    = cyc_cnt;
      shd_stall_d  = stall_cnt;
      shd_flush_d  = flush_cnt;
      shd_retire_d = retire_cnt;
    end
  end

  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      zrun_q       <= '0;
      snap_valid_q <= 1'b0;
      shd_cyc_q    <= '0;
      shd_stall_q  <= '0;
      shd_flush_q  <= '0;
      shd_retire_q <= '0;
    end else begin
      zrun_q       <= zrun_d;
      snap_valid_q <= snap_valid_d;
      shd_cyc_q    <= shd_cyc_d;
      shd_stall_q  <= shd_stall_d;
      shd_flush_q  <= shd_flush_d;
      shd_retire_q <= shd_retire_d;
    end
  end

  // Readout mux, unregistered so the selector can be swept within a cycle.
  always_comb begin
    snap_data_o = shd_cyc_q;
    case (snap_sel_i)
      SEL_CYCLE:  snap_data_o = shd_cyc_q;
      SEL_STALL:  snap_data_o = shd_stall_q;
      SEL_FLUSH:  snap_data_o = shd_flush_q;
      SEL_RETIRE: snap_data_o = shd_retire_q;
      default:    snap_data_o = shd_cyc_q;
    endcase
  end

  assign snap_valid_o = snap_valid_q;
  assign done_o       = done_c;

endmodule
